// File: rtl/line_op_arbiter.sv
// line_op_arbiter
//   Round-robin arbiter sharing one line drawing engine among NUM_REQ op
//   producers. The winning op is registered into a single output stage and
//   tagged with its source index.
//
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     req_op        NUM_REQ packed ops, requester i at [i*OP_WIDTH +: OP_WIDTH]
//     req_rts       per-requester valid
//     req_rtr       one-hot (or zero) accept, combinational
//     out_op        registered op to engine
//     out_src       index of the requester that produced out_op
//     out_rts       out_op valid
//     out_rtr       engine can accept
//     busy          mirror of out_rts
//     grant_count   per-requester saturating 16-bit accept counters
//                   (only when LINE_ARB_STATS_EN is defined)
//
//   Optional feature macro: LINE_ARB_STATS_EN

`ifdef LINE_ARB_STATS_EN
// Saturating per-requester accept counter.
module line_op_arbiter_grant_ctr (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && count != 16'hFFFF)
            count <= count + 16'd1;
    end
endmodule
`endif

module line_op_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOG2_NUM_REQ = 2,
    parameter int OP_WIDTH     = 52
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*OP_WIDTH-1:0]  req_op,
    input  logic [NUM_REQ-1:0]           req_rts,
    output logic [NUM_REQ-1:0]           req_rtr,
    output logic [OP_WIDTH-1:0]          out_op,
    output logic [LOG2_NUM_REQ-1:0]      out_src,
    output logic                         out_rts,
    input  logic                         out_rtr,
    output logic                         busy
`ifdef LINE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]        grant_count
`endif
);

    logic [NUM_REQ-1:0][OP_WIDTH-1:0] op_arr;
    logic [LOG2_NUM_REQ-1:0]          ptr;
    logic [2*NUM_REQ-1:0]             rts_dbl;
    logic [NUM_REQ-1:0]               rts_rot;
    logic [LOG2_NUM_REQ:0]            sum;
    logic [LOG2_NUM_REQ-1:0]          win;
    logic                             found;
    logic                             ld;
    logic                             accept;

    assign op_arr = req_op;

    // Rotate the request vector so bit 0 is the requester at ptr; the first
    // set bit of the rotated vector is the round-robin winner.
    assign rts_dbl = {req_rts, req_rts};
    assign rts_rot = NUM_REQ'(rts_dbl >> ptr);

    always_comb begin
        found = 1'b0;
        sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rts_rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (LOG2_NUM_REQ + 1)'(k);
            end
        end
        // Wrap modulo NUM_REQ, which need not be a power of two.
        if (sum >= (LOG2_NUM_REQ + 1)'(NUM_REQ))
            win = LOG2_NUM_REQ'(sum - (LOG2_NUM_REQ + 1)'(NUM_REQ));
        else
            win = LOG2_NUM_REQ'(sum);
    end

    // Stage accepts when empty or when draining on this same edge.
    assign ld      = !out_rts || out_rtr;
    assign accept  = ld && found && !rst;
    assign req_rtr = accept ? (NUM_REQ'(1) << win) : '0;
    assign busy    = out_rts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_rts <= 1'b0;
            out_op  <= '0;
            out_src <= '0;
            ptr     <= '0;
        end else if (accept) begin
            out_rts <= 1'b1;
            out_op  <= op_arr[win];
            out_src <= win;
            ptr     <= (win == LOG2_NUM_REQ'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end else if (out_rtr) begin
            out_rts <= 1'b0;
        end
    end

`ifdef LINE_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        line_op_arbiter_grant_ctr u_ctr (
            .clk   (clk),
            .rst   (rst),
            .inc   (req_rtr[g]),
            .count (grant_count[g*16 +: 16])
        );
    end
`endif

endmodule

// File: tb/tb_line_op_arbiter.sv
module tb_line_op_arbiter;
    localparam int N4 = 4;
    localparam int N3 = 3;
    localparam int W  = 52;
    localparam logic [W-1:0] SINGLE_OP = 52'h0_0000_0500_AABC;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic [N4*W-1:0] op4 = '0;
    logic [N4-1:0]   rts4 = '0;
    logic            ortr4 = 1'b0;
    logic [N4-1:0]   rtr4;
    logic [W-1:0]    oop4;
    logic [1:0]      osrc4;
    logic            orts4, busy4;

    logic [N3*W-1:0] op3 = '0;
    logic [N3-1:0]   rts3 = '0;
    logic            ortr3 = 1'b0;
    logic [N3-1:0]   rtr3;
    logic [W-1:0]    oop3;
    logic [1:0]      osrc3;
    logic            orts3, busy3;

`ifdef LINE_ARB_STATS_EN
    logic [N4*16-1:0] gc4;
    logic [N3*16-1:0] gc3;
`endif

    line_op_arbiter #(.NUM_REQ(N4), .LOG2_NUM_REQ(2), .OP_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req_op(op4), .req_rts(rts4), .req_rtr(rtr4),
        .out_op(oop4), .out_src(osrc4), .out_rts(orts4), .out_rtr(ortr4), .busy(busy4)
`ifdef LINE_ARB_STATS_EN
        , .grant_count(gc4)
`endif
    );

    line_op_arbiter #(.NUM_REQ(N3), .LOG2_NUM_REQ(2), .OP_WIDTH(W)) dut3 (
        .clk(clk), .rst(rst), .req_op(op3), .req_rts(rts3), .req_rtr(rtr3),
        .out_op(oop3), .out_src(osrc3), .out_rts(orts3), .out_rtr(ortr3), .busy(busy3)
`ifdef LINE_ARB_STATS_EN
        , .grant_count(gc3)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one output slot plus a "next to look at" index.
    logic         m4_valid = 1'b0, m3_valid = 1'b0;
    logic [W-1:0] m4_op = '0, m3_op = '0;
    int           m4_src = 0, m3_src = 0, m4_ptr = 0, m3_ptr = 0;
    int           mw4, mw3;

    function automatic int winner(input logic [15:0] rts, input int ptr, input int n);
        for (int k = 0; k < n; k++)
            if (rts[(ptr + k) % n]) return (ptr + k) % n;
        return -1;
    endfunction

    function automatic logic [15:0] exp_rtr(input logic [15:0] rts, input int ptr, input int n,
                                            input logic valid, input logic ortr, input logic r);
        int w;
        if (r || (valid && !ortr)) return 16'h0;
        w = winner(rts, ptr, n);
        if (w < 0) return 16'h0;
        return 16'h1 << w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m4_valid = 1'b0; m4_op = '0; m4_src = 0; m4_ptr = 0;
            m3_valid = 1'b0; m3_op = '0; m3_src = 0; m3_ptr = 0;
        end else begin
            mw4 = winner(16'(rts4), m4_ptr, N4);
            if ((!m4_valid || ortr4) && mw4 >= 0) begin
                m4_valid = 1'b1; m4_op = op4[mw4*W +: W]; m4_src = mw4; m4_ptr = (mw4 + 1) % N4;
            end else if (m4_valid && ortr4) m4_valid = 1'b0;
            mw3 = winner(16'(rts3), m3_ptr, N3);
            if ((!m3_valid || ortr3) && mw3 >= 0) begin
                m3_valid = 1'b1; m3_op = op3[mw3*W +: W]; m3_src = mw3; m3_ptr = (mw3 + 1) % N3;
            end else if (m3_valid && ortr3) m3_valid = 1'b0;
        end
    end

    function automatic logic [W-1:0] rand_op();
        return W'({$urandom(), $urandom()});
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N4; i++) op4[i*W +: W] = rand_op();
        for (int i = 0; i < N3; i++) op3[i*W +: W] = rand_op();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rand_ops();
        rts4 = '1; rts3 = '1; ortr4 = 1'b1; ortr3 = 1'b1;
        #1;
        checks++; if (rtr4 !== 4'b0) begin errors++; $display("FAIL reset_rtr4 got %b exp 0000", rtr4); end
        checks++; if (orts4 !== 1'b0) begin errors++; $display("FAIL reset_rts4 got %b exp 0", orts4); end
        checks++; if (oop4 !== '0) begin errors++; $display("FAIL reset_op4 got %h exp 0", oop4); end
        checks++; if (osrc4 !== 2'd0) begin errors++; $display("FAIL reset_src4 got %0d exp 0", osrc4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4 got %b exp 0", busy4); end
        checks++; if (rtr3 !== 3'b0 || orts3 !== 1'b0) begin errors++; $display("FAIL reset_dut3 got rtr %b rts %b exp 000 0", rtr3, orts3); end
`ifdef LINE_ARB_STATS_EN
        checks++; if (gc4 !== '0) begin errors++; $display("FAIL reset_gc4 got %h exp 0", gc4); end
`endif
        tick();
        checks++; if (orts4 !== 1'b0) begin errors++; $display("FAIL reset_hold_rts4 got %b exp 0", orts4); end
        rst = 1'b0; rts4 = '0; rts3 = '0;
        #1;
        checks++; if (rtr4 !== 4'b0) begin errors++; $display("FAIL idle_rtr4 got %b exp 0000", rtr4); end
    endtask

    task automatic test_single();
        op4[2*W +: W] = SINGLE_OP; rts4 = 4'b0100; ortr4 = 1'b1;
        #1;
        checks++; if (rtr4 !== 4'b0100) begin errors++; $display("FAIL single_rtr got %b exp 0100", rtr4); end
        tick();
        checks++; if (oop4 !== SINGLE_OP) begin errors++; $display("FAIL single_op got %h exp %h", oop4, SINGLE_OP); end
        checks++; if (osrc4 !== 2'd2 || orts4 !== 1'b1) begin errors++; $display("FAIL single_src got %0d/%b exp 2/1", osrc4, orts4); end
        rts4 = '1;
        #1;
        checks++; if (rtr4 !== 4'b1000) begin errors++; $display("FAIL single_ptr3 got %b exp 1000", rtr4); end
        tick();
        checks++; if (osrc4 !== 2'd3) begin errors++; $display("FAIL single_next got %0d exp 3", osrc4); end
    endtask

    task automatic test_round_robin();
        rts4 = '1; ortr4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            tick();
            checks++; if (osrc4 !== 2'(i % 4) || orts4 !== 1'b1) begin errors++; $display("FAIL rr_%0d got src %0d rts %b exp %0d 1", i, osrc4, orts4, i % 4); end
            checks++; if (oop4 !== m4_op) begin errors++; $display("FAIL rr_op_%0d got %h exp %h", i, oop4, m4_op); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held, nxt;
        held = m4_op;
        ortr4 = 1'b0; rts4 = '1;
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            #1;
            checks++; if (rtr4 !== 4'b0) begin errors++; $display("FAIL bp_rtr_%0d got %b exp 0000", i, rtr4); end
            tick();
            checks++; if (oop4 !== held || osrc4 !== 2'd3 || orts4 !== 1'b1) begin errors++; $display("FAIL bp_hold_%0d got %h/%0d/%b exp %h/3/1", i, oop4, osrc4, orts4, held); end
        end
        ortr4 = 1'b1;
        nxt = op4[0 +: W];
        #1;
        checks++; if (rtr4 !== 4'b0001) begin errors++; $display("FAIL bp_release_rtr got %b exp 0001", rtr4); end
        tick();
        checks++; if (orts4 !== 1'b1 || osrc4 !== 2'd0 || oop4 !== nxt) begin errors++; $display("FAIL bp_no_bubble got %b/%0d/%h exp 1/0/%h", orts4, osrc4, oop4, nxt); end
    endtask

    task automatic test_reset_mid();
        ortr4 = 1'b0; rts4 = '1;
        tick();
        checks++; if (orts4 !== 1'b1) begin errors++; $display("FAIL mid_pre_rts got %b exp 1", orts4); end
        #2 rst = 1'b1;
        #1;
        checks++; if (orts4 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL mid_clear got rts %b busy %b exp 0 0", orts4, busy4); end
        checks++; if (rtr4 !== 4'b0 || orts3 !== 1'b0) begin errors++; $display("FAIL mid_rtr got %b rts3 %b exp 0000 0", rtr4, orts3); end
        tick();
        rst = 1'b0; ortr4 = 1'b1; rts4 = '1;
        #1;
        checks++; if (rtr4 !== 4'b0001) begin errors++; $display("FAIL mid_restart_rtr got %b exp 0001", rtr4); end
        tick();
        checks++; if (osrc4 !== 2'd0 || orts4 !== 1'b1) begin errors++; $display("FAIL mid_restart_src got %0d/%b exp 0/1", osrc4, orts4); end
    endtask

    task automatic test_wrap3();
        int seq [3] = '{1, 2, 0};
        rand_ops();
        rts3 = 3'b010; ortr3 = 1'b1;
        #1;
        checks++; if (rtr3 !== 3'b010) begin errors++; $display("FAIL wrap_setup_rtr got %b exp 010", rtr3); end
        tick();
        checks++; if (osrc3 !== 2'd1) begin errors++; $display("FAIL wrap_setup_src got %0d exp 1", osrc3); end
        rts3 = 3'b001;
        #1;
        checks++; if (rtr3 !== 3'b001) begin errors++; $display("FAIL wrap_rtr got %b exp 001", rtr3); end
        tick();
        checks++; if (osrc3 !== 2'd0) begin errors++; $display("FAIL wrap_src got %0d exp 0", osrc3); end
        rts3 = 3'b111;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rtr3 !== 3'(1 << seq[i])) begin errors++; $display("FAIL wrap_seq_rtr_%0d got %b exp %0d", i, rtr3, seq[i]); end
            tick();
            checks++; if (osrc3 !== 2'(seq[i])) begin errors++; $display("FAIL wrap_seq_src_%0d got %0d exp %0d", i, osrc3, seq[i]); end
        end
        rts3 = '0;
    endtask

    task automatic test_random();
        logic [15:0] e4, e3;
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            rts4  = ($urandom_range(0, 7) == 0) ? '0 : 4'($urandom());
            rts3  = ($urandom_range(0, 7) == 0) ? '0 : 3'($urandom());
            ortr4 = ($urandom_range(0, 3) != 0);
            ortr3 = ($urandom_range(0, 1) != 0);
            #1;
            e4 = exp_rtr(16'(rts4), m4_ptr, N4, m4_valid, ortr4, rst);
            e3 = exp_rtr(16'(rts3), m3_ptr, N3, m3_valid, ortr3, rst);
            checks++; if (rtr4 !== e4[3:0]) begin errors++; $display("FAIL rnd_rtr4_%0d got %b exp %b", i, rtr4, e4[3:0]); end
            checks++; if (rtr3 !== e3[2:0]) begin errors++; $display("FAIL rnd_rtr3_%0d got %b exp %b", i, rtr3, e3[2:0]); end
            tick();
            checks++; if (orts4 !== m4_valid || busy4 !== m4_valid || oop4 !== m4_op || osrc4 !== 2'(m4_src))
                begin errors++; $display("FAIL rnd_out4_%0d got %b/%h/%0d exp %b/%h/%0d", i, orts4, oop4, osrc4, m4_valid, m4_op, m4_src); end
            checks++; if (orts3 !== m3_valid || oop3 !== m3_op || osrc3 !== 2'(m3_src))
                begin errors++; $display("FAIL rnd_out3_%0d got %b/%h/%0d exp %b/%h/%0d", i, orts3, oop3, osrc3, m3_valid, m3_op, m3_src); end
        end
    endtask

`ifdef LINE_ARB_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        #1;
        checks++; if (gc4 !== '0) begin errors++; $display("FAIL stats_clear got %h exp 0", gc4); end
        tick();
        rst = 1'b0; rts4 = 4'b0010; ortr4 = 1'b1; rts3 = '0;
        repeat (5) tick();
        checks++; if (gc4[31:16] !== 16'd5) begin errors++; $display("FAIL stats_count5 got %0d exp 5", gc4[31:16]); end
        repeat (69995) tick();
        checks++; if (gc4[31:16] !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got %h exp FFFF", gc4[31:16]); end
        checks++; if (gc4[15:0] !== 16'h0 || gc4[63:32] !== 32'h0) begin errors++; $display("FAIL stats_others got %h exp 0", gc4); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_wrap3();
        test_random();
`ifdef LINE_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/line_op_arbiter.md
# line_op_arbiter

Round-robin arbiter that shares one line drawing engine among NUM_REQ independent op producers (e.g. CPU command port, sprite/text front ends). Each requester presents a 52-bit line op over an rts/rtr handshake. The arbiter selects one requester per transfer and registers the op into a single output stage that drives the engine's input FIFO. Each forwarded op is tagged with its source index.

## Interface
- NUM_REQ, 4: number of requester ports, 2..16.
- LOG2_NUM_REQ, 2: width of source index, ceil(log2(NUM_REQ)).
- OP_WIDTH, 52: op width, {x1[9:0], y1[9:0], x2[9:0], y2[9:0], color[11:0]}.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_op  in  NUM_REQ*OP_WIDTH  requester ops; requester i occupies bits [i*OP_WIDTH +: OP_WIDTH].
- req_rts  in  NUM_REQ  requester i has a valid op.
- req_rtr  out  NUM_REQ  one-hot or zero; the arbiter accepts requester i's op this cycle.
- out_op  out  OP_WIDTH  registered op to engine.
- out_src  out  LOG2_NUM_REQ  index of requester that produced out_op.
- out_rts  out  1  out_op valid.
- out_rtr  in  1  engine input FIFO can accept.
- busy  out  1  equals out_rts.
- grant_count  out  NUM_REQ*16  present only with LINE_ARB_STATS_EN (see Configuration).

## Operation
- State: output register {valid, out_op, out_src}; round-robin pointer ptr[LOG2_NUM_REQ-1:0].
- Winner: first i with req_rts[i] set, searching ptr, ptr+1, …, wrapping NUM_REQ-1 → 0. No winner if req_rts == 0.
- Load enable: ld = !valid || out_rtr. The stage can accept when empty, or when draining in the same cycle.
- req_rtr[w] = ld && winner exists && !rst. All other bits are 0. It is combinational from req_rts, ptr, valid and out_rtr.
- Accept (req_rts[w] && req_rtr[w]):
  - out_op ← req_op slice w.
  - out_src ← w.
  - valid ← 1.
  - ptr ← (w == NUM_REQ-1) ? 0 : w+1.
- Drain without accept (valid && out_rtr && no winner): valid ← 0. out_op and out_src hold their last values.
- Stall (valid && !out_rtr): out_op, out_src and valid hold. All req_rtr are 0. ptr holds.
- Out-of-range ptr values cannot occur. Wrap uses NUM_REQ-1, not a power of two.
- The arbiter never modifies op contents and never reorders ops from the same requester.

## Timing
- Reset values: out_rts 0, out_op 0, out_src 0, busy 0, ptr 0, req_rtr all 0, grant_count 0.
- Latency: an op accepted at edge N is on out_op with out_rts=1 after edge N.
- Throughput: one op per cycle sustained when out_rtr is held high.
- out_op and out_src are stable while out_rts && !out_rtr.
- Simultaneous drain and accept: out_rtr=1 with valid=1 and a winner present. The new op replaces the old one in the same edge; there is no bubble.
- Fairness: with all requesters continuously ready and out_rtr=1, grants go 0,1,…,NUM_REQ-1,0,… Worst-case wait for a ready requester is NUM_REQ-1 transfers.
- Requester dropping rts before it is accepted: no effect on ptr.
- Reset mid-operation:
  - Asserting rst immediately clears valid and forces req_rtr to 0. Any pending op is discarded.
  - After deassertion, arbitration restarts from ptr=0.
- Combinational path exists from out_rtr to req_rtr. The downstream FIFO's in_rtr must be registered.

## Configuration
- LINE_ARB_STATS_EN defined:
  - Adds output grant_count, a 16-bit counter per requester at slice [i*16 +: 16].
  - Each counter increments on every accept from requester i and saturates at 16'hFFFF.
  - Counters are cleared by rst only.
- LINE_ARB_STATS_EN undefined: the grant_count port and its counters are absent. All other behaviour is identical.

## Test plan
- Reset mid-stream: stall with out_rtr=0 so out_rts=1, then pulse rst. Required: out_rts=0, req_rtr=0 immediately. After release, first grant goes to 0 when all requesters are ready.
- Single requester: req_rts=4'b0100, op=52'h0_0000_0050_0A_ABC, out_rtr=1. Required: req_rtr=4'b0100; next cycle out_op equals the op, out_src=2; ptr=3.
- All ready, out_rtr=1 for 8 cycles. Required: out_src sequence 0,1,2,3,0,1,2,3 with out_rts high continuously.
- Backpressure: valid op held, out_rtr=0 for 5 cycles with all requesters ready. Required: req_rtr=0 and out_op unchanged throughout. When out_rtr=1, the drain and the next accept happen in the same cycle.
- Wrap with NUM_REQ=3: ptr=2, only requester 0 ready. Required: grant to 0 and ptr becomes 1. Then req_rts=3'b111 gives grant 1, then 2, then 0.
- With LINE_ARB_STATS_EN: 70000 accepts from requester 1. Required: grant_count[31:16]=16'hFFFF (saturated) and the other counters stay 0.
